// File: rtl/fitness_kernel_mul_pipe.sv
// fitness_kernel_mul_pipe: signed/unsigned multiplier with a valid/ready elastic pipeline carrying a sideband tag
module fitness_kernel_mul_pipe #(
    parameter int din0_WIDTH = 64,
    parameter int din1_WIDTH = 66,
    parameter int dout_WIDTH = 130,
    parameter int NUM_STAGE  = 3,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  is_signed,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0]  out_tag
);
    localparam int P  = din0_WIDTH + din1_WIDTH + 1;
    localparam int MW = dout_WIDTH < P ? dout_WIDTH : P;

    logic [MW-1:0]         ext0, ext1, prod;
    logic [dout_WIDTH-1:0] res;
    logic [NUM_STAGE-1:0]  vld, adv;
    logic [dout_WIDTH-1:0] dat [NUM_STAGE];
    logic [TAG_WIDTH-1:0]  tag [NUM_STAGE];

    // Only the low MW product bits are ever visible, so the multiply is done at that width
    assign ext0 = MW'({{(P - din0_WIDTH){is_signed & din0[din0_WIDTH-1]}}, din0});
    assign ext1 = MW'({{(P - din1_WIDTH){is_signed & din1[din1_WIDTH-1]}}, din1});
    assign prod = ext0 * ext1;

    generate
        if (dout_WIDTH > P) begin : g_ext
            assign res = {{(dout_WIDTH - P){is_signed & prod[P-1]}}, prod};
        end else begin : g_trunc
            assign res = prod;
        end
    endgenerate

    // Stage k may advance when any stage from k to the end has a hole, or the sink drains
    always_comb begin
        for (int k = 0; k < NUM_STAGE; k++)
            adv[k] = out_ready || !(&(vld | NUM_STAGE'((1 << k) - 1)));
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[NUM_STAGE-1];
    assign dout      = dat[NUM_STAGE-1];
    assign out_tag   = tag[NUM_STAGE-1];

    // Stage shift register: valid bits always follow, data only loads behind a valid transfer
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                dat[k] <= '0;
                tag[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= res;
                    tag[0] <= in_tag;
                end
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        dat[k] <= dat[k-1];
                        tag[k] <= tag[k-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fitness_kernel_mul_pipe.sv
// tb_fitness_kernel_mul_pipe: scoreboard bench over three pipeline depth / result width configurations
module tb_fitness_kernel_mul_pipe;
    logic clk = 0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int g, logic [159:0] act, logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cfg%0d %s: got %0h, expected %0h", g, nm, act, exp);
        end
    endtask

    // Reference product via magnitudes, then sign applied at the full 131-bit width
    function automatic logic [130:0] ref_mul(logic [63:0] a, logic [65:0] b, logic s);
        logic na, nb;
        logic [63:0] ua;
        logic [65:0] ub;
        logic [130:0] p;
        na = s & a[63];
        nb = s & b[65];
        ua = na ? -a : a;
        ub = nb ? -b : b;
        p = ua * ub;
        return (na ^ nb) ? -p : p;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int N  = g == 0 ? 3 : g == 1 ? 1 : 8;
        localparam int DW = g == 0 ? 130 : g == 1 ? 8 : 140;
        typedef struct { logic [DW-1:0] d; logic [7:0] t; int c; bit l; } exp_t;
        logic rst_n, in_valid, in_ready, is_signed, out_valid, out_ready;
        logic [63:0] din0;
        logic [65:0] din1;
        logic [7:0] in_tag, out_tag;
        logic [DW-1:0] dout;
        bit rnd;
        bit done = 0;
        exp_t q[$];

        fitness_kernel_mul_pipe #(.dout_WIDTH(DW), .NUM_STAGE(N)) dut (
            .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .din0(din0), .din1(din1), .is_signed(is_signed), .in_tag(in_tag),
            .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_tag(out_tag)
        );

        function automatic logic [DW-1:0] fit(logic [130:0] p, logic s);
            logic [139:0] x;
            x = {{9{s & p[130]}}, p};
            return x[DW-1:0];
        endfunction

        task automatic tick();
            @(negedge clk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            #1;
        endtask

        task automatic send(logic [63:0] a, logic [65:0] b, logic s, logic [7:0] t, logic [130:0] p, bit l);
            int n = 0;
            din0 = a; din1 = b; is_signed = s; in_tag = t; in_valid = 1;
            #1;
            while (!in_ready && n < 200) begin
                tick();
                n++;
            end
            chk("accept", g, in_ready, 1);
            if (in_ready) q.push_back('{fit(p, s), t, cyc, l});
            tick();
            in_valid = 0;
        endtask

        task automatic drain();
            int n = 0;
            out_ready = 1;
            while (q.size() > 0 && n < 100) begin
                tick();
                n++;
            end
            chk("drain", g, q.size(), 0);
        endtask

        always @(negedge clk) begin
            #2;
            if (rst_n && out_valid) begin
                if (q.size() == 0) chk("spurious_valid", g, out_valid, 0);
                else begin
                    chk("dout", g, dout, q[0].d);
                    chk("out_tag", g, out_tag, q[0].t);
                    if (out_ready) begin
                        if (q[0].l) chk("latency", g, cyc - q[0].c, N);
                        void'(q.pop_front());
                    end
                end
            end
        end

        initial begin
            logic [63:0] a;
            logic [65:0] b;
            logic s;
            rst_n = 0; in_valid = 0; din0 = 0; din1 = 0; is_signed = 0; in_tag = 0;
            out_ready = 1; rnd = 0;
            tick();
            tick();
            chk("rst_out_valid", g, out_valid, 0);
            chk("rst_dout", g, dout, 0);
            chk("rst_out_tag", g, out_tag, 0);
            rst_n = 1;
            tick();
            chk("rst_in_ready", g, in_ready, 1);
            send(64'hFFFF_FFFF_FFFF_FFFF, 66'd2, 0, 8'h5A, 131'h1_FFFF_FFFF_FFFF_FFFE, 1);
            send(64'hFFFF_FFFF_FFFF_FFFD, 66'd7, 1, 8'h01, -131'sd21, 1);
            send(64'd3, 66'd7, 0, 8'h02, 131'd21, 1);
            send(64'h1F, 66'h11, 0, 8'h03, 131'h20F, 1);
            send(64'h8000_0000_0000_0000, 66'h3_FFFF_FFFF_FFFF_FFFF, 1, 8'h04, 131'h8000_0000_0000_0000, 1);
            send(64'hFFFF_FFFF_FFFF_FFFF, 66'h3_FFFF_FFFF_FFFF_FFFF, 0, 8'h05,
                 131'h3_FFFF_FFFF_FFFF_FFFB_0000_0000_0000_0001, 1);
            send(64'hFFFF_FFFF_FFFF_FFFF, 66'h3_FFFF_FFFF_FFFF_FFFF, 1, 8'h06, 131'd1, 1);
            drain();
            out_ready = 0;
            for (int i = 0; i < N; i++)
                send(64'(i + 10), 66'(i + 1), 0, 8'(i), 131'((i + 10) * (i + 1)), 0);
            tick();
            tick();
            chk("full_in_ready", g, in_ready, 0);
            out_ready = 1;
            #1;
            chk("pass_in_ready", g, in_ready, 1);
            for (int i = N; i < N + 2; i++)
                send(64'(i + 10), 66'(i + 1), 0, 8'(i), 131'((i + 10) * (i + 1)), 0);
            drain();
            send(64'd100, 66'd3, 0, 8'hA0, 131'd300, 0);
            send(64'd200, 66'd3, 0, 8'hA1, 131'd600, 0);
            rst_n = 0;
            #1;
            chk("midrst_out_valid", g, out_valid, 0);
            chk("midrst_dout", g, dout, 0);
            chk("midrst_out_tag", g, out_tag, 0);
            q.delete();
            din0 = 64'd9; din1 = 66'd9; in_tag = 8'hEE; in_valid = 1;
            tick();
            tick();
            in_valid = 0;
            rst_n = 1;
            tick();
            chk("midrst_in_ready", g, in_ready, 1);
            send(64'hFFFF_FFFF_FFFF_FFFB, 66'd9, 1, 8'h77, -131'sd45, 1);
            drain();
            rnd = 1;
            for (int i = 0; i < 40; i++) begin
                a = {$urandom(), $urandom()};
                b = {2'($urandom()), $urandom(), $urandom()};
                s = 1'($urandom());
                repeat ($urandom_range(0, 2)) tick();
                send(a, b, s, 8'(i + 16), ref_mul(a, b, s), 0);
            end
            rnd = 0;
            drain();
            done = 1;
        end
    end

    initial begin
        for (int i = 0; i < 5000 && !(cfg[0].done && cfg[1].done && cfg[2].done); i++) @(negedge clk);
        chk("all_done", -1, {cfg[0].done, cfg[1].done, cfg[2].done}, 3'b111);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fitness_kernel_mul_pipe.md
FITNESS_KERNEL_MUL_PIPE -- requirements
Module: fitness_kernel_mul_pipe

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 64, operand A width.
REQ-002 SHALL have parameter din1_WIDTH, default 66, operand B width.
REQ-003 SHALL have parameter dout_WIDTH, default 130, result width (any value 1..din0_WIDTH+din1_WIDTH+1).
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline depth (legal 1..8).
REQ-005 SHALL have parameter TAG_WIDTH, default 8, sideband tag width.
REQ-006 SHALL have port ap_clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid  input  1  operand transfer request.
REQ-009 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-010 SHALL have port din0  input  din0_WIDTH  operand A.
REQ-011 SHALL have port din1  input  din1_WIDTH  operand B.
REQ-012 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled per transfer.
REQ-013 SHALL have port in_tag  input  TAG_WIDTH  sideband carried with the operands.
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 SHALL have port dout  output  dout_WIDTH  product.
REQ-017 SHALL have port out_tag  output  TAG_WIDTH  tag of the transfer in dout.

Function
REQ-018 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-019 The pipeline SHALL have NUM_STAGE register stages, each with a valid bit; stage k SHALL advance when empty or when stage k+1 advances; the last stage advances when out_ready=1.
REQ-020 in_ready SHALL be 1 when stage 0 is empty or stage 0 advances this cycle (combinational, no added bubble).
REQ-021 With out_ready held 1, latency SHALL be exactly NUM_STAGE cycles from input transfer to out_valid, throughput one result per cycle.
REQ-022 While out_valid=1 and out_ready=0, dout and out_tag SHALL hold stable; the pipeline SHALL fill until all NUM_STAGE stages are valid, then in_ready=0.
REQ-023 No transfer SHALL be dropped, duplicated or reordered under any valid/ready pattern.
REQ-024 Full product SHALL be computed at width P=din0_WIDTH+din1_WIDTH+1 by extending each operand with one bit: sign bit if is_signed=1, zero otherwise.
REQ-025 If dout_WIDTH<=P, dout SHALL be the low dout_WIDTH bits of the product (modulo truncation); if dout_WIDTH>P, dout SHALL be the product sign-extended (is_signed=1) or zero-extended.
REQ-026 is_signed and in_tag SHALL travel with their operands; mixing modes on consecutive transfers SHALL give each result its own mode.
REQ-027 Simultaneous input and output transfers on a full pipeline SHALL both complete in the same cycle.
REQ-028 Data registers of invalid stages MAY hold any value; out_valid SHALL never assert for them.

Reset
REQ-029 ap_rst_n=0 SHALL clear all stage valid bits immediately (asynchronously), forcing out_valid=0, in_ready=1 (once ap_rst_n=1), dout=0, out_tag=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transfers; first accepted transfer after deassertion SHALL appear NUM_STAGE cycles later.
REQ-031 Input transfers SHALL be ignored while ap_rst_n=0.

Verification
REQ-032 Unsigned, defaults: din0=0xFFFFFFFFFFFFFFFF, din1=2, tag=0x5A, out_ready=1 -> out_valid after 3 cycles, dout=0x1FFFFFFFFFFFFFFFE, out_tag=0x5A.
REQ-033 Signed, defaults: din0=-3, din1=7 -> dout=-21 sign-extended to 130 bits; next cycle unsigned 3*7 -> dout=21, both in order.
REQ-034 Backpressure: stream 5 transfers, out_ready=0 -> in_ready drops after 3 accepted, dout stable; release out_ready -> all 5 results in order, tags 0..4.
REQ-035 Truncation, dout_WIDTH=8: din0=0x1F, din1=0x11 unsigned -> dout=0x0F (0x20F mod 256).
REQ-036 Reset mid-stream: 2 transfers in flight, pulse ap_rst_n low -> out_valid=0 at once, neither result ever emitted; new transfer emitted NUM_STAGE cycles after acceptance.
REQ-037 Random valid/ready on both sides, NUM_STAGE in {1,3,8}, random mode -> scoreboard matches reference product for every transfer, no loss or reorder.
